// File: rtl/return_addr_stack_pkg.sv
// Shared widths for the return-address stack and the fetch PC mux.
// Default depth, address width and pointer-width helper.
package return_addr_stack_pkg;

    localparam int RAS_DEPTH = 8;
    localparam int RAS_AW    = 32;

    function automatic int ptrW(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/return_addr_stack_ptr.sv
// Top/count update unit for the return-address stack.
// Circular push/pop arithmetic with an optional restore path.
import return_addr_stack_pkg::*;

module ras_ptr #(
    parameter int DEPTH          = RAS_DEPTH,
    parameter int PW             = ptrW(RAS_DEPTH),
    parameter bit PAIR_EMPTY_PUSH = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          restore,
    input  logic [PW-1:0] restoreTop,
    input  logic [PW:0]   restoreCnt,
    output logic [PW-1:0] top,
    output logic [PW:0]   cnt,
    output logic [PW-1:0] nextTop,
    output logic [PW:0]   nextCnt
);

    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic isEmpty;

    assign isEmpty = (cnt == '0);

    // Next pointer/count: restore wins, call+ret on a non-empty stack is a replace.
    always_comb begin
        nextTop = top;
        nextCnt = cnt;
        if (restore) begin
            nextTop = restoreTop;
            nextCnt = restoreCnt;
        end else if (push && pop) begin
            if (isEmpty && PAIR_EMPTY_PUSH) begin
                nextTop = top + PW'(1);
                nextCnt = cnt + (PW+1)'(1);
            end
        end else if (push) begin
            nextTop = top + PW'(1);
            if (cnt != FULL) begin
                nextCnt = cnt + (PW+1)'(1);
            end
        end else if (pop && !isEmpty) begin
            nextTop = top - PW'(1);
            nextCnt = cnt - (PW+1)'(1);
        end
    end

    // Pointer/count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            top <= '0;
            cnt <= '0;
        end else begin
            top <= nextTop;
            cnt <= nextCnt;
        end
    end

endmodule

// File: rtl/return_addr_stack.sv
// Speculative return-address stack feeding the fetch PC select mux.
// Committed pointers restore the speculative ones on a branch miss.
import return_addr_stack_pkg::*;

module return_addr_stack #(
    parameter int DEPTH = RAS_DEPTH,
    parameter int AW    = RAS_AW
) (
    input  logic          iClk,
    input  logic          iReset,
    input  logic          iStall,
    input  logic          iCallCmd,
    input  logic [AW-1:0] iNextPC,
    input  logic          iRetReq,
    input  logic          iCommitCall,
    input  logic          iCommitRet,
    input  logic          iBranchMissCmd,
    output logic [AW-1:0] oRetAddr,
    output logic          oRetCmd,
    output logic          oEmpty,
    output logic          oFull
);

    localparam int PTR_W = ptrW(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    logic [AW-1:0]    mem [DEPTH];
    logic [PTR_W-1:0] sTop;
    logic [PTR_W:0]   sCnt;
    logic [PTR_W-1:0] sNextTop;
    logic [PTR_W:0]   sNextCnt;
    logic [PTR_W-1:0] cTop;
    logic [PTR_W:0]   cCnt;
    logic [PTR_W-1:0] cNextTop;
    logic [PTR_W:0]   cNextCnt;
    logic             specPush;
    logic             specPop;
    logic             wrEn;
    logic [PTR_W-1:0] wrIdx;
    logic             unusedBits;

    assign specPush = iCallCmd & ~iStall;
    assign specPop  = iRetReq & ~iStall;

    ras_ptr #(
        .DEPTH          (DEPTH),
        .PW             (PTR_W),
        .PAIR_EMPTY_PUSH(1'b1)
    ) specPtr (
        .clk       (iClk),
        .reset     (iReset),
        .push      (specPush),
        .pop       (specPop),
        .restore   (iBranchMissCmd),
        .restoreTop(cNextTop),
        .restoreCnt(cNextCnt),
        .top       (sTop),
        .cnt       (sCnt),
        .nextTop   (sNextTop),
        .nextCnt   (sNextCnt)
    );

    ras_ptr #(
        .DEPTH          (DEPTH),
        .PW             (PTR_W),
        .PAIR_EMPTY_PUSH(1'b0)
    ) commitPtr (
        .clk       (iClk),
        .reset     (iReset),
        .push      (iCommitCall),
        .pop       (iCommitRet),
        .restore   (1'b0),
        .restoreTop('0),
        .restoreCnt('0),
        .top       (cTop),
        .cnt       (cCnt),
        .nextTop   (cNextTop),
        .nextCnt   (cNextCnt)
    );

    assign unusedBits = ^{cTop, cCnt, sNextTop, sNextCnt};

    assign oEmpty   = (sCnt == '0);
    assign oFull    = (sCnt == FULL);
    assign oRetAddr = mem[sTop];
    assign oRetCmd  = iRetReq & ~oEmpty;

    // Call+ret on a live stack replaces the top; otherwise write above it.
    assign wrEn  = specPush & ~iBranchMissCmd;
    assign wrIdx = (specPop && !oEmpty) ? sTop : sTop + PTR_W'(1);

    // Entry storage; never restored on a branch miss.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wrEn) begin
            mem[wrIdx] <= iNextPC;
        end
    end

endmodule

// File: tb/tb_return_addr_stack.sv
// Directed testbench for return_addr_stack.
// Hand-computed expectations checked through one task.
module tb_return_addr_stack;

    localparam int AW = 32;

    logic          iClk = 1'b0;
    logic          iReset;
    logic          iStall;
    logic          iCallCmd;
    logic [AW-1:0] iNextPC;
    logic          iRetReq;
    logic          iCommitCall;
    logic          iCommitRet;
    logic          iBranchMissCmd;
    logic [AW-1:0] oRetAddr;
    logic          oRetCmd;
    logic          oEmpty;
    logic          oFull;

    int testCnt = 0;
    int failCnt = 0;

    always #5 iClk = ~iClk;

    return_addr_stack dut (
        .iClk          (iClk),
        .iReset        (iReset),
        .iStall        (iStall),
        .iCallCmd      (iCallCmd),
        .iNextPC       (iNextPC),
        .iRetReq       (iRetReq),
        .iCommitCall   (iCommitCall),
        .iCommitRet    (iCommitRet),
        .iBranchMissCmd(iBranchMissCmd),
        .oRetAddr      (oRetAddr),
        .oRetCmd       (oRetCmd),
        .oEmpty        (oEmpty),
        .oFull         (oFull)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        testCnt++;
        if (got !== exp) begin
            failCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic idle();
        iStall = 0; iCallCmd = 0; iNextPC = '0; iRetReq = 0;
        iCommitCall = 0; iCommitRet = 0; iBranchMissCmd = 0;
    endtask

    task automatic doReset();
        idle();
        iReset = 1;
        step();
        step();
        iReset = 0;
    endtask

    task automatic push(input logic [31:0] a, input logic commit);
        iCallCmd = 1; iNextPC = a; iCommitCall = commit;
        step();
        idle();
    endtask

    task automatic popChk(input string tag, input logic [31:0] a,
                          input logic cmd);
        iRetReq = 1;
        #1;
        check({tag, ".cmd"}, 32'(oRetCmd), 32'(cmd));
        if (cmd) check({tag, ".addr"}, oRetAddr, a);
        step();
        idle();
    endtask

    initial begin
        idle();
        iReset = 1;
        step();
        step();
        iReset = 0;

        // 1: reset state
        iRetReq = 1;
        #1;
        check("rst.cmd", 32'(oRetCmd), 0);
        check("rst.empty", 32'(oEmpty), 1);
        check("rst.full", 32'(oFull), 0);
        check("rst.addr", oRetAddr, 0);
        step();
        idle();
        check("rst.underflow", 32'(oEmpty), 1);

        // 2: basic push/pop and underflow
        push(32'h100, 0);
        push(32'h200, 0);
        popChk("t2.pop1", 32'h200, 1);
        popChk("t2.pop2", 32'h100, 1);
        popChk("t2.pop3", 32'h0, 0);
        check("t2.empty", 32'(oEmpty), 1);

        // 3: wrap on 9 pushes into 8 entries
        for (int i = 1; i <= 9; i++) push(32'(i * 16), 0);
        check("t3.full", 32'(oFull), 1);
        check("t3.top", oRetAddr, 32'h90);
        for (int i = 0; i < 8; i++)
            popChk($sformatf("t3.pop%0d", i), 32'(32'h90 - i * 16), 1);
        check("t3.empty", 32'(oEmpty), 1);
        check("t3.nofull", 32'(oFull), 0);

        // 4: stall holds speculative state
        doReset();
        push(32'h100, 0);
        iStall = 1; iCallCmd = 1; iNextPC = 32'h300; iRetReq = 1;
        #1;
        check("t4.cmd", 32'(oRetCmd), 1);
        check("t4.addrBefore", oRetAddr, 32'h100);
        step();
        check("t4.addrAfter", oRetAddr, 32'h100);
        check("t4.notEmpty", 32'(oEmpty), 0);
        iRetReq = 0;
        #1;
        check("t4.cmdOff", 32'(oRetCmd), 0);
        idle();
        popChk("t4.pop", 32'h100, 1);
        check("t4.empty", 32'(oEmpty), 1);

        // 5: branch miss restores committed pointers, drops same-cycle call
        doReset();
        push(32'h100, 1);
        push(32'h200, 1);
        push(32'h300, 0);
        popChk("t5.pop1", 32'h300, 1);
        popChk("t5.pop2", 32'h200, 1);
        iBranchMissCmd = 1; iCallCmd = 1; iNextPC = 32'h999;
        step();
        idle();
        check("t5.addr", oRetAddr, 32'h200);
        popChk("t5.pop3", 32'h200, 1);
        popChk("t5.pop4", 32'h100, 1);
        check("t5.empty", 32'(oEmpty), 1);

        // 6: call+ret same cycle replaces top
        doReset();
        push(32'h100, 0);
        iCallCmd = 1; iNextPC = 32'h400; iRetReq = 1;
        #1;
        check("t6.addrNow", oRetAddr, 32'h100);
        check("t6.cmdNow", 32'(oRetCmd), 1);
        step();
        idle();
        check("t6.addrAfter", oRetAddr, 32'h400);
        popChk("t6.pop", 32'h400, 1);
        check("t6.empty", 32'(oEmpty), 1);

        // call+ret on empty stack is a plain push
        iCallCmd = 1; iNextPC = 32'h500; iRetReq = 1;
        #1;
        check("t6.emptyCmd", 32'(oRetCmd), 0);
        step();
        idle();
        check("t6.emptyPush", oRetAddr, 32'h500);
        check("t6.notEmpty", 32'(oEmpty), 0);

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule
